hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage RISC-V core. Generates the per-stage load enables (the hazard "locker" signals) and bubble/flush requests for the IF_ID, DEC_ALU and ALU_MEM registers. Resolves load-use stalls, taken-branch flushes and multi-cycle data-cache waits, and keeps saturating stall/flush statistics. Sits beside the decoder; consumes the EX-stage opcode and addresses returned by DEC_ALU.

## Interface
- MEM_TIMEOUT, 255: MEM_WAIT cycles before `memTimeout` sets.
- CNT_W, 16: width of statistics counters.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- opCodeEx  in  `OpcodeSize`  opcode of the instruction in EX (from DEC_ALU).
- exRd  in  `RegAddrSize`  destination register of the instruction in EX.
- idRs1, idRs2  in  `RegAddrSize` each  source registers of the instruction in ID.
- idUsesRs1, idUsesRs2  in  1 each  ID instruction actually reads rs1/rs2.
- branchTaken  in  1  EX resolved a taken branch/jump this cycle.
- memReq  in  1  MEM-stage instruction accesses the data cache.
- memReady  in  1  data cache completes the access this cycle.
- pcEnable, ifIdEnable, decAluEnable, aluMemEnable  out  1 each  stage register loads when 1, holds when 0.
- ifIdFlush, decAluFlush  out  1 each  stage register loads a NOP (writeEnable 0, cache control idle) instead of its inputs.
- memTimeout  out  1  sticky; MEM_WAIT exceeded MEM_TIMEOUT.
- stallCycles, flushCount  out  CNT_W each  saturating statistics.

## Operation
- States: RUN, MEM_WAIT. State register and counters update on posedge clk; stage-control outputs are combinational from state and inputs.
- loadUse = (opCodeEx == LOAD 7'b0000011) && exRd != 0 && ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd)).
- memMiss = memReq && !memReady.
- RUN, priority memMiss > branchTaken > loadUse > none:
  - memMiss: all four enables 0, flushes 0; next state MEM_WAIT; stallCycles +1.
  - branchTaken: all enables 1, ifIdFlush = decAluFlush = 1; flushCount +1; stay RUN.
  - loadUse: pcEnable = ifIdEnable = 0, decAluEnable = aluMemEnable = 1, decAluFlush = 1 (one bubble); stallCycles +1.
  - none: all enables 1, flushes 0.
- MEM_WAIT: while !memReady, all enables 0, flushes 0, stallCycles +1, wait counter +1; when the counter reaches MEM_TIMEOUT, set memTimeout (stays set until reset; waiting continues). On memReady: outputs as RUN evaluated without memMiss (branchTaken/loadUse then apply in that same cycle), wait counter cleared, next state RUN.
- branchTaken and loadUse during MEM_WAIT are not acted on; EX is frozen, so they remain asserted and are applied on the release cycle.
- Counters saturate at all-ones; no wrap.
- Reset (at any point, including mid-MEM_WAIT): state RUN, wait counter 0, memTimeout 0, stallCycles 0, flushCount 0. While reset is high: all enables 1, ifIdFlush = decAluFlush = 1, so the pipeline registers load NOPs.

## Timing
- Load-use costs exactly 1 bubble cycle. The dependent instruction enters DEC_ALU on the following edge.
- Taken branch kills 2 slots (ID and IF) in the same cycle as branchTaken, with no added stall.
- A data-cache access whose memReady arrives N cycles after memReq rises costs N stall cycles. memReq && memReady in the same cycle costs 0.
- memTimeout rises on the edge at which the wait counter reaches MEM_TIMEOUT.
- All outputs are valid in the same cycle as their inputs; no registered output latency except memTimeout and the counters.

## Structure
- Shared defines header holds `OpcodeSize`, `RegAddrSize` and the opcode constants (LOAD, BRANCH, JAL, JALR).
- State encoding is local to the block.
- One sub-module: `sat_counter` (parameter width, inc, clear, saturating). Instantiate it for stallCycles, flushCount and the MEM_WAIT counter.

## Test plan
- Load-use: opCodeEx = 7'b0000011, exRd = 5, idRs1 = 5, idUsesRs1 = 1 -> pcEnable = ifIdEnable = 0, decAluFlush = 1 for 1 cycle; stallCycles 0 -> 1. Same with exRd = 0 -> no stall.
- Branch + load-use in the same cycle -> ifIdFlush = decAluFlush = 1, all enables 1, flushCount +1, stallCycles unchanged.
- memReq with memReady after 3 cycles -> enables 0 for 3 cycles, released on the 4th, stallCycles = 3; memReq && memReady together -> no stall.
- MEM_TIMEOUT = 4, memReady withheld 6 cycles -> memTimeout rises after 4 wait cycles, stays high after release, clears only on reset.
- Reset asserted in MEM_WAIT -> next cycle state RUN, counters 0, memTimeout 0; during reset, enables 1 and flushes 1.
- Force stallCycles (CNT_W = 4) to 15, cause another stall -> stays 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared core widths, opcode constants and the stage-control bundle
// used by the pipeline sequencing controller.
package hazard_ctrl_pkg;

  localparam int OpcodeSize  = 7;
  localparam int RegAddrSize = 5;

  localparam logic [OpcodeSize-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OpcodeSize-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OpcodeSize-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OpcodeSize-1:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic dec_alu_en;
    logic alu_mem_en;
    logic if_id_flush;
    logic dec_alu_flush;
  } stage_ctrl_t;

  function automatic logic load_use(
    input logic [OpcodeSize-1:0]  op_ex,
    input logic [RegAddrSize-1:0] rd_ex,
    input logic [RegAddrSize-1:0] rs1,
    input logic [RegAddrSize-1:0] rs2,
    input logic                   use1,
    input logic                   use2
  );
    logic hit1;
    logic hit2;
    hit1 = use1 && (rs1 == rd_ex);
    hit2 = use2 && (rs2 == rd_ex);
    return (op_ex == OP_LOAD) && (rd_ex != '0) && (hit1 || hit2);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stage load enables, bubbles and
// flushes for load-use, taken branches and data-cache waits.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [OpcodeSize-1:0]  opCodeEx,
  input  logic [RegAddrSize-1:0] exRd,
  input  logic [RegAddrSize-1:0] idRs1,
  input  logic [RegAddrSize-1:0] idRs2,
  input  logic                   idUsesRs1,
  input  logic                   idUsesRs2,
  input  logic                   branchTaken,
  input  logic                   memReq,
  input  logic                   memReady,
  output logic                   pcEnable,
  output logic                   ifIdEnable,
  output logic                   decAluEnable,
  output logic                   aluMemEnable,
  output logic                   ifIdFlush,
  output logic                   decAluFlush,
  output logic                   memTimeout,
  output logic [CNT_W-1:0]       stallCycles,
  output logic [CNT_W-1:0]       flushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic             timeout_q;
  logic             timeout_d;
  logic [WAIT_W-1:0] wait_cnt;

  logic        mem_miss;
  logic        lu_hit;
  logic        waiting;
  logic        wait_inc;
  logic        wait_clr;
  logic        stall_inc;
  logic        flush_inc;
  stage_ctrl_t ctrl;

  assign mem_miss = memReq && !memReady;
  assign lu_hit   = load_use(opCodeEx, exRd, idRs1, idRs2,
                             idUsesRs1, idUsesRs2);
  assign waiting  = (state_q == RUN) ? mem_miss : !memReady;
  assign wait_inc = (state_q == MEM_WAIT) && !memReady;
  assign wait_clr = (state_q == MEM_WAIT) && memReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN:      if (mem_miss) state_d = MEM_WAIT;
      MEM_WAIT: if (memReady) state_d = RUN;
      default:  state_d = RUN;
    endcase
    // sticky flag rises on the edge the counter reaches the limit
    if (wait_inc && (wait_cnt == WAIT_LAST)) begin
      timeout_d = 1'b1;
    end
  end

  always_comb begin
    ctrl      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (reset) begin
      ctrl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    end else if (waiting) begin
      ctrl      = '0;
      stall_inc = 1'b1;
    end else if (branchTaken) begin
      ctrl      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      flush_inc = 1'b1;
    end else if (lu_hit) begin
      ctrl      = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      stall_inc = 1'b1;
    end
  end

  assign pcEnable     = ctrl.pc_en;
  assign ifIdEnable   = ctrl.if_id_en;
  assign decAluEnable = ctrl.dec_alu_en;
  assign aluMemEnable = ctrl.alu_mem_en;
  assign ifIdFlush    = ctrl.if_id_flush;
  assign decAluFlush  = ctrl.dec_alu_flush;
  assign memTimeout   = timeout_q;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (stall_inc),
    .count (stallCycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .inc   (flush_inc),
    .count (flushCount)
  );

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (wait_clr),
    .inc   (wait_inc),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised and directed bench for hazard_ctrl against a cycle-level
// reference model of the sequencing rules.
module tb_hazard_ctrl;

  localparam int MT = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opCodeEx;
  logic [4:0]    exRd;
  logic [4:0]    idRs1;
  logic [4:0]    idRs2;
  logic          idUsesRs1;
  logic          idUsesRs2;
  logic          branchTaken;
  logic          memReq;
  logic          memReady;
  logic          pcEnable;
  logic          ifIdEnable;
  logic          decAluEnable;
  logic          aluMemEnable;
  logic          ifIdFlush;
  logic          decAluFlush;
  logic          memTimeout;
  logic [CW-1:0] stallCycles;
  logic [CW-1:0] flushCount;

  int checks = 0;
  int errors = 0;

  bit m_wait;
  int m_wcnt;
  bit m_to;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .opCodeEx     (opCodeEx),
    .exRd         (exRd),
    .idRs1        (idRs1),
    .idRs2        (idRs2),
    .idUsesRs1    (idUsesRs1),
    .idUsesRs2    (idUsesRs2),
    .branchTaken  (branchTaken),
    .memReq       (memReq),
    .memReady     (memReady),
    .pcEnable     (pcEnable),
    .ifIdEnable   (ifIdEnable),
    .decAluEnable (decAluEnable),
    .aluMemEnable (aluMemEnable),
    .ifIdFlush    (ifIdFlush),
    .decAluFlush  (decAluFlush),
    .memTimeout   (memTimeout),
    .stallCycles  (stallCycles),
    .flushCount   (flushCount)
  );

  function automatic bit lu_now();
    bit h1;
    bit h2;
    h1 = idUsesRs1 && (idRs1 == exRd);
    h2 = idUsesRs2 && (idRs2 == exRd);
    return (opCodeEx == 7'b0000011) && (exRd != 0) && (h1 || h2);
  endfunction

  function automatic bit miss_now();
    if (m_wait) return !memReady;
    return memReq && !memReady;
  endfunction

  // {pc, ifId, decAlu, aluMem, ifIdFlush, decAluFlush}
  function automatic logic [5:0] exp_ctrl();
    if (reset) return 6'b111111;
    if (miss_now()) return 6'b000000;
    if (branchTaken) return 6'b111111;
    if (lu_now()) return 6'b001101;
    return 6'b111100;
  endfunction

  function automatic logic [5:0] obs_ctrl();
    return {pcEnable, ifIdEnable, decAluEnable, aluMemEnable,
            ifIdFlush, decAluFlush};
  endfunction

  task automatic model_step();
    if (reset) begin
      m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else if (miss_now()) begin
      if (m_stall < CMAX) m_stall++;
      if (m_wait) begin
        m_wcnt++;
        if (m_wcnt >= MT) m_to = 1;
      end
      m_wait = 1;
    end else begin
      m_wait = 0;
      m_wcnt = 0;
      if (branchTaken) begin
        if (m_flush < CMAX) m_flush++;
      end else if (lu_now()) begin
        if (m_stall < CMAX) m_stall++;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    reset = 0; opCodeEx = 7'b0110011; exRd = 0; idRs1 = 0; idRs2 = 0;
    idUsesRs1 = 0; idUsesRs2 = 0; branchTaken = 0;
    memReq = 0; memReady = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    advance();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    memReq = 1;
    #1;
    checks++;
    if (obs_ctrl() !== 6'b111111) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 111111", obs_ctrl());
    end
    advance();
    reset = 0;
    memReq = 0;
    checks++;
    if (stallCycles !== 0 || flushCount !== 0 || memTimeout !== 0) begin
      errors++;
      $display("FAIL reset_state got s=%0d f=%0d to=%b want 0 0 0",
               stallCycles, flushCount, memTimeout);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    opCodeEx = 7'b0000011; exRd = 5; idRs1 = 5; idUsesRs1 = 1;
    #1;
    checks++;
    if (obs_ctrl() !== 6'b001101) begin
      errors++;
      $display("FAIL load_use_ctrl got %b want 001101", obs_ctrl());
    end
    advance();
    checks++;
    if (stallCycles !== 1) begin
      errors++;
      $display("FAIL load_use_stall got %0d want 1", stallCycles);
    end
    exRd = 0; idRs1 = 0;
    #1;
    checks++;
    if (obs_ctrl() !== 6'b111100) begin
      errors++;
      $display("FAIL load_use_x0 got %b want 111100", obs_ctrl());
    end
    advance();
    checks++;
    if (stallCycles !== 1) begin
      errors++;
      $display("FAIL load_use_x0_stall got %0d want 1", stallCycles);
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    opCodeEx = 7'b0000011; exRd = 7; idRs2 = 7; idUsesRs2 = 1;
    branchTaken = 1;
    #1;
    checks++;
    if (obs_ctrl() !== 6'b111111) begin
      errors++;
      $display("FAIL branch_lu_ctrl got %b want 111111", obs_ctrl());
    end
    advance();
    checks++;
    if (flushCount !== 1 || stallCycles !== 0) begin
      errors++;
      $display("FAIL branch_lu_cnt got f=%0d s=%0d want 1 0",
               flushCount, stallCycles);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    memReq = 1; memReady = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (obs_ctrl() !== 6'b000000) begin
        errors++;
        $display("FAIL mem_wait_c%0d got %b want 000000", i, obs_ctrl());
      end
      advance();
    end
    memReady = 1;
    #1;
    checks++;
    if (obs_ctrl() !== 6'b111100) begin
      errors++;
      $display("FAIL mem_release got %b want 111100", obs_ctrl());
    end
    advance();
    checks++;
    if (stallCycles !== 3) begin
      errors++;
      $display("FAIL mem_stall got %0d want 3", stallCycles);
    end
    #1;
    checks++;
    if (obs_ctrl() !== 6'b111100) begin
      errors++;
      $display("FAIL mem_hit got %b want 111100", obs_ctrl());
    end
    advance();
    checks++;
    if (stallCycles !== 3) begin
      errors++;
      $display("FAIL mem_hit_stall got %0d want 3", stallCycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    memReq = 1; memReady = 0;
    advance();
    for (int k = 1; k <= 5; k++) begin
      advance();
      checks++;
      if (memTimeout !== (k >= MT)) begin
        errors++;
        $display("FAIL timeout_w%0d got %b want %b", k, memTimeout, k >= MT);
      end
    end
    memReady = 1;
    advance();
    memReq = 0; memReady = 0;
    advance();
    checks++;
    if (memTimeout !== 1 || stallCycles !== 6) begin
      errors++;
      $display("FAIL timeout_sticky got to=%b s=%0d want 1 6",
               memTimeout, stallCycles);
    end
    do_reset();
    checks++;
    if (memTimeout !== 0) begin
      errors++;
      $display("FAIL timeout_clear got %b want 0", memTimeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    branchTaken = 1;
    advance();
    branchTaken = 0;
    memReq = 1; memReady = 0;
    advance();
    advance();
    reset = 1;
    #1;
    checks++;
    if (obs_ctrl() !== 6'b111111) begin
      errors++;
      $display("FAIL midwait_reset_ctrl got %b want 111111", obs_ctrl());
    end
    advance();
    reset = 0; memReq = 0; memReady = 0;
    #1;
    checks++;
    if (obs_ctrl() !== 6'b111100 || stallCycles !== 0 ||
        flushCount !== 0 || memTimeout !== 0) begin
      errors++;
      $display("FAIL midwait_after got c=%b s=%0d f=%0d to=%b want 111100 0 0 0",
               obs_ctrl(), stallCycles, flushCount, memTimeout);
    end
    advance();
  endtask

  task automatic test_saturation();
    do_reset();
    opCodeEx = 7'b0000011; exRd = 3; idRs1 = 3; idUsesRs1 = 1;
    for (int i = 0; i < CMAX + 2; i++) advance();
    checks++;
    if (stallCycles !== 4'(CMAX)) begin
      errors++;
      $display("FAIL stall_sat got %0d want %0d", stallCycles, CMAX);
    end
    opCodeEx = 7'b0110011; branchTaken = 1;
    for (int i = 0; i < CMAX + 3; i++) advance();
    checks++;
    if (flushCount !== 4'(CMAX)) begin
      errors++;
      $display("FAIL flush_sat got %0d want %0d", flushCount, CMAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      opCodeEx    = ($urandom_range(0, 1) == 0) ? 7'b0000011 : 7'b0110011;
      exRd        = 5'($urandom_range(0, 3));
      idRs1       = 5'($urandom_range(0, 3));
      idRs2       = 5'($urandom_range(0, 3));
      idUsesRs1   = 1'($urandom_range(0, 1));
      idUsesRs2   = 1'($urandom_range(0, 1));
      branchTaken = ($urandom_range(0, 4) == 0);
      memReq      = ($urandom_range(0, 2) == 0);
      memReady    = ($urandom_range(0, 2) == 0);
      #1;
      checks++;
      if (obs_ctrl() !== exp_ctrl()) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got %b want %b", n, obs_ctrl(), exp_ctrl());
      end
      advance();
      checks++;
      if (stallCycles !== 4'(m_stall) || flushCount !== 4'(m_flush) ||
          memTimeout !== m_to) begin
        errors++;
        $display("FAIL rand_state[%0d] got s=%0d f=%0d to=%b want %0d %0d %b",
                 n, stallCycles, flushCount, memTimeout, m_stall, m_flush, m_to);
      end
    end
  endtask

  initial begin
    idle_inputs();
    m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
